dht11_scheduler: RTL and testbench

Sequences the DHT11 single-wire controller. It is the sole source of that controller's start pulse. It merges manual read requests with a periodic auto-read timer, enforces the sensor's minimum inter-read gap and a response timeout, and retries failed or invalid reads. It latches the last good humidity/temperature pair for the display/UART side and sits between the button/UART command logic and the DHT11 controller.

---
 rtl/dht11_sched_pkg.sv | 21 ++
 rtl/dht11_scheduler_tick.sv | 35 +++
 rtl/dht11_scheduler.sv | 179 +++++++++++++++++
 tb/tb_dht11_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dht11_sched_pkg.sv
// Shared definitions for the DHT11 read scheduler.
// Holds the scheduler state encoding, the error-counter ceiling and the
// helper that turns a clock frequency into a 1 ms tick divisor.
package dht11_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } sched_state_t;

  localparam int unsigned ERR_CNT_MAX = 255;

  // Clock cycles per millisecond, never less than one so the tick
  // generator stays well formed for very slow clocks.
  function automatic int unsigned ms_tick_div(input int unsigned clk_hz);
    return (clk_hz / 1000 > 0) ? clk_hz / 1000 : 1;
  endfunction

endpackage

// File: rtl/dht11_scheduler_tick.sv
// tick_gen_1m: free-running millisecond tick generator.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   tick  - one-cycle pulse every CLK_HZ/1000 cycles
module tick_gen_1m #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  import dht11_sched_pkg::*;

  localparam int unsigned DIV   = ms_tick_div(CLK_HZ);
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;

  // Divider wraps on its last count and emits the tick in the same edge,
  // so the tick is registered and one cycle wide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CNT_W'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CNT_W'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/dht11_scheduler.sv
// dht11_scheduler: sequences reads of the DHT11 controller.
// Merges manual requests with a periodic auto-read timer, enforces the
// inter-read gap and a response timeout, retries failed reads and keeps
// the last good humidity/temperature pair.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   manual_req          - one-cycle read request
//   auto_en             - level, enables periodic reads
//   dht_done/dht_valid  - controller completion and checksum status
//   dht_humidity/_temperature - raw controller data
//   dht_start           - one-cycle start pulse to the controller
//   busy                - a transaction or its trailing gap is in progress
//   humidity/temperature, data_valid, update - last good reading
//   fail, err_cnt       - retry exhaustion flag, saturating error count
module dht11_scheduler #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned PERIOD_MS  = 2000,
  parameter int unsigned MIN_GAP_MS = 1200,
  parameter int unsigned TIMEOUT_MS = 30,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        manual_req,
  input  logic        auto_en,
  input  logic        dht_done,
  input  logic        dht_valid,
  input  logic [15:0] dht_humidity,
  input  logic [15:0] dht_temperature,
  output logic        dht_start,
  output logic        busy,
  output logic [15:0] humidity,
  output logic [15:0] temperature,
  output logic        data_valid,
  output logic        update,
  output logic        fail,
  output logic [7:0]  err_cnt
);
  import dht11_sched_pkg::*;

  localparam int unsigned MS_MAX_A = (PERIOD_MS > MIN_GAP_MS) ? PERIOD_MS : MIN_GAP_MS;
  localparam int unsigned MS_MAX   = (MS_MAX_A > TIMEOUT_MS) ? MS_MAX_A : TIMEOUT_MS;
  localparam int unsigned MS_W     = $clog2(MS_MAX + 1);
  localparam int unsigned RETRY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  sched_state_t state, next_state;

  logic               tick;
  logic [MS_W-1:0]    ms_cnt;
  logic [MS_W-1:0]    auto_cnt;
  logic               pend;
  logic               retry_pend;
  logic [RETRY_W-1:0] retry_cnt;

  logic auto_fire;
  logic take_req;
  logic timeout_hit;
  logic gap_done;
  logic good_rd;
  logic bad_rd;
  logic retry_left;

  tick_gen_1m #(
    .CLK_HZ(CLK_HZ)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign auto_fire   = auto_en && tick && (auto_cnt == MS_W'(PERIOD_MS - 1));
  assign take_req    = (state == IDLE) && (pend || retry_pend);
  assign timeout_hit = (ms_cnt >= MS_W'(TIMEOUT_MS));
  assign gap_done    = (ms_cnt >= MS_W'(MIN_GAP_MS));
  // A valid done wins over a timeout that lands in the same cycle.
  assign good_rd     = (state == WAIT_DONE) && dht_done && dht_valid;
  assign bad_rd      = (state == WAIT_DONE) &&
                       ((dht_done && !dht_valid) || (!dht_done && timeout_hit));
  assign retry_left  = (retry_cnt < RETRY_W'(MAX_RETRY));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Leaving WAIT_DONE on the first done cycle is what
  // makes a multi-cycle done level count as a single completion.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:      if (take_req) next_state = ISSUE;
      ISSUE:     next_state = WAIT_DONE;
      WAIT_DONE: if (good_rd || bad_rd) next_state = GAP;
      GAP:       if (gap_done) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    dht_start = (state == ISSUE);
    busy      = (state != IDLE);
  end

  // Auto-read period counter; held at zero while auto mode is off so each
  // enable starts a full period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_cnt <= '0;
    end else if (!auto_en) begin
      auto_cnt <= '0;
    end else if (tick) begin
      auto_cnt <= (auto_cnt == MS_W'(PERIOD_MS - 1)) ? '0 : auto_cnt + MS_W'(1);
    end
  end

  // Millisecond counter shared by the timeout and the gap; restarted on
  // issue and again on entry to GAP, and saturating so it cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms_cnt <= '0;
    end else if ((state == ISSUE) || ((state != GAP) && (next_state == GAP))) begin
      ms_cnt <= '0;
    end else if (tick && ((state == WAIT_DONE) || (state == GAP)) &&
                 (ms_cnt != MS_W'(MS_MAX))) begin
      ms_cnt <= ms_cnt + MS_W'(1);
    end
  end

  // Request flags. Consumption takes priority, so a request arriving in
  // the cycle a read is committed is folded into that read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= 1'b0;
      retry_pend <= 1'b0;
    end else if (take_req) begin
      pend       <= 1'b0;
      retry_pend <= 1'b0;
    end else begin
      if (manual_req || auto_fire) pend <= 1'b1;
      if (bad_rd && retry_left) retry_pend <= 1'b1;
    end
  end

  // Result bookkeeping: reading latch, retry accounting and error status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      humidity    <= '0;
      temperature <= '0;
      data_valid  <= 1'b0;
      update      <= 1'b0;
      fail        <= 1'b0;
      err_cnt     <= '0;
      retry_cnt   <= '0;
    end else begin
      update <= good_rd;
      if (good_rd) begin
        humidity    <= dht_humidity;
        temperature <= dht_temperature;
        data_valid  <= 1'b1;
        fail        <= 1'b0;
        retry_cnt   <= '0;
      end else if (bad_rd) begin
        if (err_cnt != 8'(ERR_CNT_MAX)) err_cnt <= err_cnt + 8'd1;
        if (retry_left) begin
          retry_cnt <= retry_cnt + RETRY_W'(1);
        end else begin
          fail      <= 1'b1;
          retry_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dht11_scheduler.sv
// Self-checking bench for dht11_scheduler with a behavioural DHT11
// controller model and a scoreboard of expected readings.
module tb_dht11_scheduler;

  localparam int unsigned CLK_HZ     = 10_000;
  localparam int unsigned PERIOD_MS  = 20;
  localparam int unsigned MIN_GAP_MS = 5;
  localparam int unsigned TIMEOUT_MS = 3;
  localparam int unsigned MAX_RETRY  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        manual_req = 1'b0;
  logic        auto_en = 1'b0;
  logic        dht_done = 1'b0;
  logic        dht_valid = 1'b0;
  logic [15:0] dht_humidity = '0;
  logic [15:0] dht_temperature = '0;
  logic        dht_start;
  logic        busy;
  logic [15:0] humidity;
  logic [15:0] temperature;
  logic        data_valid;
  logic        update;
  logic        fail;
  logic [7:0]  err_cnt;

  dht11_scheduler #(
    .CLK_HZ(CLK_HZ), .PERIOD_MS(PERIOD_MS), .MIN_GAP_MS(MIN_GAP_MS),
    .TIMEOUT_MS(TIMEOUT_MS), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .manual_req(manual_req), .auto_en(auto_en),
    .dht_done(dht_done), .dht_valid(dht_valid), .dht_humidity(dht_humidity),
    .dht_temperature(dht_temperature), .dht_start(dht_start), .busy(busy),
    .humidity(humidity), .temperature(temperature), .data_valid(data_valid),
    .update(update), .fail(fail), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int start_cnt = 0;
  int update_cnt = 0;
  int start_q[$];
  logic [31:0] exp_q[$];

  // Controller model configuration (written by the main sequence only).
  logic [15:0] mh = '0;
  logic [15:0] mt = '0;
  bit model_silent = 1'b0;
  int bad_cfg = 0;
  int resp_base = 0;
  int stray_req = 0;
  // Model-owned state.
  int resp_cnt = 0;
  int last_done = 0;

  typedef struct {
    bit          silent;
    int          n_bad;
    logic [15:0] h;
    logic [15:0] t;
    int          exp_starts;
    int          exp_updates;
    logic [7:0]  exp_err;
    logic        exp_fail;
    logic [15:0] exp_h;
    logic [15:0] exp_t;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkRange(input string name, input int val, input int lo, input int hi);
    tests++;
    if (val < lo || val > hi) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
    end
  endtask

  // One cycle step, sampling just after the falling edge; also acts as
  // the output monitor and the scoreboard consumer.
  task automatic step();
    logic [31:0] e;
    @(negedge clk);
    #1;
    if (dht_start) begin
      start_cnt++;
      start_q.push_back(cyc);
    end
    if (update) begin
      update_cnt++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL update_unexpected: got update pulse expected none");
      end else begin
        e = exp_q.pop_front();
        checkOutput("sb_humidity", {16'h0, humidity}, {16'h0, e[31:16]});
        checkOutput("sb_temperature", {16'h0, temperature}, {16'h0, e[15:0]});
      end
    end
  endtask

  task automatic applyStimulus();
    manual_req = 1'b1;
    step();
    manual_req = 1'b0;
  endtask

  task automatic waitQuiet(input int budget, output int idle_cyc);
    int quiet;
    quiet = 0;
    idle_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (busy) quiet = 0;
      else begin
        if (quiet == 0) idle_cyc = cyc;
        quiet++;
      end
      if (quiet >= 4) return;
    end
    tests++;
    fails++;
    $display("[TB] FAIL wait_idle: busy after %0d cycles, expected idle", budget);
  endtask

  task automatic waitStart(input int s0, input int budget, input string name);
    int k;
    k = 0;
    while (start_cnt == s0 && k < budget) begin
      step();
      k++;
    end
    checkOutput(name, {31'h0, start_cnt != s0}, 32'h1);
  endtask

  // Behavioural controller: answers each start after 2 ms with a 3-cycle
  // done level; the first bad_cfg answers of a vector carry a bad checksum.
  initial begin
    int seen;
    bit good;
    seen = 0;
    forever begin
      @(negedge clk);
      if (stray_req != seen) begin
        seen = stray_req;
        dht_humidity = 16'hBEEF;
        dht_temperature = 16'hCAFE;
        dht_valid = 1'b1;
        dht_done = 1'b1;
        repeat (3) @(negedge clk);
        dht_done = 1'b0;
        dht_valid = 1'b0;
      end else if (dht_start && !model_silent) begin
        repeat (20) @(negedge clk);
        good = (resp_cnt - resp_base) >= bad_cfg;
        resp_cnt++;
        dht_humidity = mh;
        dht_temperature = mt;
        dht_valid = good;
        dht_done = 1'b1;
        last_done = cyc;
        if (good) exp_q.push_back({mh, mt});
        repeat (3) @(negedge clk);
        dht_done = 1'b0;
        dht_valid = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s0, u0, q0, idle_c, first;
    bit found;

    vecs[0] = '{1'b0, 0, 16'h3A05, 16'h1B00, 1, 1, 8'd0, 1'b0, 16'h3A05, 16'h1B00};
    vecs[1] = '{1'b0, 1, 16'h3800, 16'h1B05, 2, 1, 8'd1, 1'b0, 16'h3800, 16'h1B05};
    vecs[2] = '{1'b1, 0, 16'h1111, 16'h2222, 3, 0, 8'd4, 1'b1, 16'h3800, 16'h1B05};
    vecs[3] = '{1'b0, 0, 16'h4000, 16'h1900, 1, 1, 8'd4, 1'b0, 16'h4000, 16'h1900};
    vecs[4] = '{1'b0, 3, 16'h5555, 16'h6666, 3, 0, 8'd7, 1'b1, 16'h4000, 16'h1900};
    vecs[5] = '{1'b0, 2, 16'h4101, 16'h1C02, 3, 1, 8'd9, 1'b0, 16'h4101, 16'h1C02};

    // Reset state.
    repeat (3) step();
    checkOutput("reset_flags", {27'h0, dht_start, busy, data_valid, update, fail}, 32'h0);
    checkOutput("reset_err_cnt", {24'h0, err_cnt}, 32'h0);
    checkOutput("reset_data", {humidity, temperature}, 32'h0);
    rst_n = 1'b1;
    repeat (5) step();

    // Manual read: start latency, result latch and gap length.
    mh = 16'h3700; mt = 16'h1A00; bad_cfg = 0; resp_base = resp_cnt;
    u0 = update_cnt;
    applyStimulus();
    checkOutput("latency_no_early_start", {31'h0, dht_start}, 32'h0);
    step();
    checkOutput("latency_start_2cyc", {31'h0, dht_start}, 32'h1);
    checkOutput("issue_busy", {31'h0, busy}, 32'h1);
    waitQuiet(800, idle_c);
    checkRange("done_to_idle", idle_c - last_done, 40, 56);
    checkOutput("manual_updates", update_cnt - u0, 32'd1);
    checkOutput("manual_data", {humidity, temperature}, 32'h37001A00);
    checkOutput("manual_data_valid", {31'h0, data_valid}, 32'h1);

    // Table of single-request scenarios with retries and timeouts.
    for (int i = 0; i < 6; i++) begin
      mh = vecs[i].h; mt = vecs[i].t;
      model_silent = vecs[i].silent;
      bad_cfg = vecs[i].n_bad;
      resp_base = resp_cnt;
      s0 = start_cnt; u0 = update_cnt; q0 = start_q.size();
      applyStimulus();
      waitQuiet(800, idle_c);
      checkOutput($sformatf("v%0d_starts", i), start_cnt - s0, vecs[i].exp_starts);
      checkOutput($sformatf("v%0d_updates", i), update_cnt - u0, vecs[i].exp_updates);
      checkOutput($sformatf("v%0d_err_cnt", i), {24'h0, err_cnt}, {24'h0, vecs[i].exp_err});
      checkOutput($sformatf("v%0d_fail", i), {31'h0, fail}, {31'h0, vecs[i].exp_fail});
      checkOutput($sformatf("v%0d_data_valid", i), {31'h0, data_valid}, 32'h1);
      checkOutput($sformatf("v%0d_data", i), {humidity, temperature}, {vecs[i].exp_h, vecs[i].exp_t});
      for (int j = q0 + 1; j < start_q.size(); j++)
        checkRange($sformatf("v%0d_retry_spacing", i), start_q[j] - start_q[j-1], 60, 90);
    end
    model_silent = 1'b0; bad_cfg = 0;

    // Auto mode for 100 ms with a manual request on an auto expiry cycle.
    mh = 16'h2222; mt = 16'h1111; resp_base = resp_cnt;
    s0 = start_cnt; u0 = update_cnt;
    auto_en = 1'b1;
    first = cyc;
    waitStart(s0, 300, "auto_first_start");
    q0 = start_q[start_q.size()-1];
    while (cyc < q0 + 198) step();
    applyStimulus();
    while (cyc < first + 1005) step();
    auto_en = 1'b0;
    waitQuiet(800, idle_c);
    checkOutput("auto_start_count", start_cnt - s0, 32'd5);
    checkOutput("auto_update_count", update_cnt - u0, 32'd5);
    found = 1'b0;
    foreach (start_q[k]) if (start_q[k] == q0 + 200) found = 1'b1;
    checkOutput("auto_coincident_start", {31'h0, found}, 32'h1);

    // Several requests during WAIT_DONE collapse into one follow-up read.
    s0 = start_cnt;
    applyStimulus();
    waitStart(s0, 10, "busy_first_start");
    step();
    applyStimulus(); step();
    applyStimulus(); step();
    applyStimulus();
    waitQuiet(800, idle_c);
    checkOutput("busy_req_starts", start_cnt - s0, 32'd2);

    // Reset in WAIT_DONE, stray done afterwards, then a fresh request.
    model_silent = 1'b1;
    s0 = start_cnt;
    applyStimulus();
    waitStart(s0, 10, "rst_seq_start");
    repeat (5) step();
    rst_n = 1'b0;
    step();
    checkOutput("midrst_flags", {27'h0, dht_start, busy, data_valid, update, fail}, 32'h0);
    checkOutput("midrst_err_cnt", {24'h0, err_cnt}, 32'h0);
    checkOutput("midrst_data", {humidity, temperature}, 32'h0);
    step();
    rst_n = 1'b1;
    u0 = update_cnt;
    repeat (20) step();
    stray_req = stray_req + 1;
    repeat (80) step();
    checkOutput("post_rst_no_start", start_cnt - s0, 32'd1);
    checkOutput("stray_done_ignored", {30'h0, data_valid, busy}, 32'h0);
    checkOutput("stray_no_update", update_cnt - u0, 32'd0);
    model_silent = 1'b0; mh = 16'h3300; mt = 16'h1500; resp_base = resp_cnt;
    applyStimulus();
    waitQuiet(800, idle_c);
    checkOutput("post_rst_read_starts", start_cnt - s0, 32'd2);
    checkOutput("post_rst_data", {humidity, temperature}, 32'h33001500);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
